ptw_dbus_arbiter: RTL and testbench



---
 rtl/ptw_dbus_arbiter_pkg.sv | 35 +++
 rtl/ptw_dbus_arbiter_pte_cache.sv | 60 ++++++
 rtl/ptw_dbus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ptw_dbus_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_dbus_arbiter_pkg.sv
// Shared types for the walker / data-port bus arbiter.
// Request fields use the package widths. Instantiate the arbiter with
// AW/DW equal to ARB_AW/ARB_DW.
package ptw_dbus_arbiter_pkg;

  localparam int ARB_AW = 64;
  localparam int ARB_DW = 64;

  // Bus size codes, log2 of the access width in bytes.
  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTW  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  // One latched bus request, shared by the walker and data ports.
  typedef struct packed {
    logic [ARB_AW-1:0]   addr;
    logic [2:0]          size;
    logic [ARB_DW/8-1:0] strobe;
    logic [ARB_DW-1:0]   wdata;
  } req_t;

  // Clears the low three bits so a byte address names its 8-byte word.
  function automatic logic [ARB_AW-1:0] dword_align(input logic [ARB_AW-1:0] a);
    return {a[ARB_AW-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/ptw_dbus_arbiter_pte_cache.sv
// Single-entry PTE cache: remembers the last PTE read by the walker.
// The entry is dropped on flush, on a data write to its 8-byte word, and on reset.
module pte_cache_entry
  import ptw_dbus_arbiter_pkg::*;
#(
  parameter int AW = ARB_AW,
  parameter int DW = ARB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          inv_en,
  input  logic [AW-1:0] inv_addr,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] hit_data
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // Next-entry logic: fill first, then invalidation. A flush overrides everything else.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d = 1'b1;
      addr_d  = fill_addr;
      data_d  = fill_data;
    end
    if (inv_en && (dword_align(inv_addr) == addr_q)) begin
      valid_d = 1'b0;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit      = valid_q && (lookup_addr == addr_q);
  assign hit_data = data_q;

endmodule

// File: rtl/ptw_dbus_arbiter.sv
// Arbitrates the data bus between page-table-walker PTE reads and
// post-translation loads/stores. The walker wins when both ports request at once.
// Optional feature macro PTW_PTE_CACHE_EN adds a single-entry PTE cache.
module ptw_dbus_arbiter
  import ptw_dbus_arbiter_pkg::*;
#(
  parameter int         AW       = ARB_AW,
  parameter int         DW       = ARB_DW,
  parameter logic [2:0] PTE_SIZE = 3'b011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ptw_req,
  input  logic [AW-1:0]   ptw_addr,
  output logic [DW-1:0]   ptw_data,
  output logic            ptw_data_valid,
  input  logic            d_req,
  input  logic [AW-1:0]   d_addr,
  input  logic [2:0]      d_size,
  input  logic [DW/8-1:0] d_strobe,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ok,
  output logic            bus_valid,
  output logic [AW-1:0]   bus_addr,
  output logic [2:0]      bus_size,
  output logic [DW/8-1:0] bus_strobe,
  output logic [DW-1:0]   bus_wdata,
  input  logic [DW-1:0]   bus_rdata,
  input  logic            bus_ok,
  input  logic            flush
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_PTW  = PTW;
  localparam logic [1:0] ST_DATA = DATA;
  localparam logic [1:0] ST_GAP  = GAP;

  logic [1:0]    state_q, state_d;
  req_t          req_q, req_d;
  logic          bus_valid_q, bus_valid_d;
  logic [DW-1:0] ptw_data_q, ptw_data_d;
  logic          ptw_data_valid_q, ptw_data_valid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_ok_q, d_ok_d;

  logic          cache_hit;
  logic [DW-1:0] cache_data;

`ifdef PTW_PTE_CACHE_EN
  pte_cache_entry #(.AW(AW), .DW(DW)) u_pte_cache (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .fill_en     ((state_q == ST_PTW) && bus_ok),
    .fill_addr   (req_q.addr),
    .fill_data   (bus_rdata),
    .inv_en      ((state_q == ST_IDLE) && !ptw_req && d_req && (|d_strobe)),
    .inv_addr    (d_addr),
    .lookup_addr (ptw_addr),
    .hit         (cache_hit),
    .hit_data    (cache_data)
  );
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign cache_hit    = 1'b0;
  assign cache_data   = '0;
`endif

  // FSM and next values of all registered outputs. Response pulses default low.
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    bus_valid_d      = bus_valid_q;
    ptw_data_d       = ptw_data_q;
    ptw_data_valid_d = 1'b0;
    d_rdata_d        = d_rdata_q;
    d_ok_d           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ptw_req) begin
          if (cache_hit) begin
            ptw_data_d       = cache_data;
            ptw_data_valid_d = 1'b1;
            state_d          = ST_GAP;
          end else begin
            req_d.addr   = ptw_addr;
            req_d.size   = PTE_SIZE;
            req_d.strobe = '0;
            req_d.wdata  = '0;
            bus_valid_d  = 1'b1;
            state_d      = ST_PTW;
          end
        end else if (d_req) begin
          req_d.addr   = d_addr;
          req_d.size   = d_size;
          req_d.strobe = d_strobe;
          req_d.wdata  = d_wdata;
          bus_valid_d  = 1'b1;
          state_d      = ST_DATA;
        end
      end
      ST_PTW: begin
        if (bus_ok) begin
          ptw_data_d       = bus_rdata;
          ptw_data_valid_d = 1'b1;
          bus_valid_d      = 1'b0;
          state_d          = ST_GAP;
        end
      end
      ST_DATA: begin
        if (bus_ok) begin
          d_rdata_d   = bus_rdata;
          d_ok_d      = 1'b1;
          bus_valid_d = 1'b0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        bus_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any transaction without a response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      req_q            <= '0;
      bus_valid_q      <= 1'b0;
      ptw_data_q       <= '0;
      ptw_data_valid_q <= 1'b0;
      d_rdata_q        <= '0;
      d_ok_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      bus_valid_q      <= bus_valid_d;
      ptw_data_q       <= ptw_data_d;
      ptw_data_valid_q <= ptw_data_valid_d;
      d_rdata_q        <= d_rdata_d;
      d_ok_q           <= d_ok_d;
    end
  end

  assign bus_valid      = bus_valid_q;
  assign bus_addr       = req_q.addr;
  assign bus_size       = req_q.size;
  assign bus_strobe     = req_q.strobe;
  assign bus_wdata      = req_q.wdata;
  assign ptw_data       = ptw_data_q;
  assign ptw_data_valid = ptw_data_valid_q;
  assign d_rdata        = d_rdata_q;
  assign d_ok           = d_ok_q;

endmodule

// File: tb/tb_ptw_dbus_arbiter.sv
// Directed bench for ptw_dbus_arbiter. The bench plays the bus slave by
// hand, one cycle at a time. Define PTW_PTE_CACHE_EN to exercise the PTE cache.
module tb_ptw_dbus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ptw_req;
  logic [63:0] ptw_addr;
  logic [63:0] ptw_data;
  logic        ptw_data_valid;
  logic        d_req;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic [63:0] d_rdata;
  logic        d_ok;
  logic        bus_valid;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_ok;
  logic        flush;

  int checks   = 0;
  int failures = 0;

  ptw_dbus_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .ptw_req        (ptw_req),
    .ptw_addr       (ptw_addr),
    .ptw_data       (ptw_data),
    .ptw_data_valid (ptw_data_valid),
    .d_req          (d_req),
    .d_addr         (d_addr),
    .d_size         (d_size),
    .d_strobe       (d_strobe),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_ok           (d_ok),
    .bus_valid      (bus_valid),
    .bus_addr       (bus_addr),
    .bus_size       (bus_size),
    .bus_strobe     (bus_strobe),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ok         (bus_ok),
    .flush          (flush)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Drive the bus response for the current cycle, then move to 1 time unit past the next edge.
  task automatic applyStimulus(input logic ok, input logic [63:0] rdata);
    bus_ok    = ok;
    bus_rdata = rdata;
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed sequence.
  initial begin
    logic [63:0] walk_addr [3];
    logic [63:0] walk_pte  [3];
    walk_addr[0] = 64'h8000_2000; walk_pte[0] = 64'h0000_0000_2000_0801;
    walk_addr[1] = 64'h8000_2ff8; walk_pte[1] = 64'h0000_0000_2000_0c01;
    walk_addr[2] = 64'h8000_3010; walk_pte[2] = 64'h0000_0000_1234_50cf;

    reset = 1'b1; ptw_req = 1'b0; ptw_addr = '0; d_req = 1'b0; d_addr = '0;
    d_size = 3'b011; d_strobe = '0; d_wdata = '0; bus_rdata = '0; bus_ok = 1'b0; flush = 1'b0;
    #1;
    applyStimulus(1'b0, 64'h0);
    applyStimulus(1'b0, 64'h0);
    checkOutput("rst_bus_valid", bus_valid, 1'b0);
    checkOutput("rst_ptw_dv", ptw_data_valid, 1'b0);
    checkOutput("rst_d_ok", d_ok, 1'b0);
    checkOutput("rst_bus_addr", bus_addr, 64'h0);
    reset = 1'b0;

    // Single PTE read.
    ptw_req = 1'b1; ptw_addr = 64'h8000_1000;
    applyStimulus(1'b0, 64'h0);
    checkOutput("ptw_bus_valid", bus_valid, 1'b1);
    checkOutput("ptw_bus_addr", bus_addr, 64'h8000_1000);
    checkOutput("ptw_bus_size", bus_size, 3'd3);
    checkOutput("ptw_bus_strobe", bus_strobe, 8'h00);
    applyStimulus(1'b1, 64'h2000_0401);
    checkOutput("ptw_dv_pulse", ptw_data_valid, 1'b1);
    checkOutput("ptw_data", ptw_data, 64'h2000_0401);
    checkOutput("ptw_gap_bus_valid", bus_valid, 1'b0);
    ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
    checkOutput("ptw_dv_end", ptw_data_valid, 1'b0);

    // Simultaneous requests: walker goes first.
    ptw_req = 1'b1; ptw_addr = 64'h8000_4000;
    d_req = 1'b1; d_addr = 64'h8000_0010; d_strobe = 8'h00;
    applyStimulus(1'b0, 64'h0);
    checkOutput("arb_first_addr", bus_addr, 64'h8000_4000);
    applyStimulus(1'b1, 64'h0000_0000_aaaa_0001);
    checkOutput("arb_ptw_dv", ptw_data_valid, 1'b1);
    checkOutput("arb_no_d_ok", d_ok, 1'b0);
    ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
    checkOutput("arb_idle_bus_valid", bus_valid, 1'b0);
    applyStimulus(1'b0, 64'h0);
    checkOutput("arb_data_valid", bus_valid, 1'b1);
    checkOutput("arb_data_addr", bus_addr, 64'h8000_0010);
    checkOutput("arb_data_wait_ok", d_ok, 1'b0);
    applyStimulus(1'b1, 64'h0000_0000_bbbb_0002);
    checkOutput("arb_d_ok", d_ok, 1'b1);
    checkOutput("arb_d_rdata", d_rdata, 64'h0000_0000_bbbb_0002);
    d_req = 1'b0;
    applyStimulus(1'b0, 64'h0);

    // Data write with a slow slave; the requester changes its fields mid-flight.
    d_req = 1'b1; d_addr = 64'h8000_0008; d_strobe = 8'hFF; d_wdata = 64'hDEAD_BEEF;
    applyStimulus(1'b0, 64'h0);
    d_addr = 64'h9999_0000; d_wdata = 64'h1111_2222; d_strobe = 8'h01;
    for (int i = 0; i < 5; i++) begin
      checkOutput("wr_hold_valid", bus_valid, 1'b1);
      checkOutput("wr_hold_addr", bus_addr, 64'h8000_0008);
      checkOutput("wr_hold_strobe", bus_strobe, 8'hFF);
      checkOutput("wr_hold_wdata", bus_wdata, 64'hDEAD_BEEF);
      checkOutput("wr_hold_no_ok", d_ok, 1'b0);
      applyStimulus(1'b0, 64'h0);
    end
    checkOutput("wr_still_valid", bus_valid, 1'b1);
    applyStimulus(1'b1, 64'h0);
    checkOutput("wr_d_ok", d_ok, 1'b1);
    d_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
    checkOutput("wr_d_ok_single", d_ok, 1'b0);

    // Three-level walk, walker moves to the next address after each PTE.
    ptw_req = 1'b1; ptw_addr = walk_addr[0];
    for (int lvl = 0; lvl < 3; lvl++) begin
      applyStimulus(1'b0, 64'h0);
      checkOutput("walk_bus_valid", bus_valid, 1'b1);
      checkOutput("walk_bus_addr", bus_addr, walk_addr[lvl]);
      applyStimulus(1'b1, walk_pte[lvl]);
      checkOutput("walk_dv", ptw_data_valid, 1'b1);
      checkOutput("walk_pte", ptw_data, walk_pte[lvl]);
      checkOutput("walk_gap", bus_valid, 1'b0);
      if (lvl < 2) ptw_addr = walk_addr[lvl + 1];
      else ptw_req = 1'b0;
      applyStimulus(1'b0, 64'h0);
      checkOutput("walk_idle", bus_valid, 1'b0);
    end

    // Reset while a PTE read is on the bus.
    ptw_req = 1'b1; ptw_addr = 64'h8000_5000;
    applyStimulus(1'b0, 64'h0);
    checkOutput("rmid_bus_valid", bus_valid, 1'b1);
    reset = 1'b1; ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
    checkOutput("rmid_bus_drop", bus_valid, 1'b0);
    checkOutput("rmid_no_dv", ptw_data_valid, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b1, 64'h0000_0000_dead_0000);
    checkOutput("rmid_still_no_dv", ptw_data_valid, 1'b0);
    checkOutput("idle_bus_ok_no_d_ok", d_ok, 1'b0);
    checkOutput("idle_bus_ok_no_valid", bus_valid, 1'b0);
    d_req = 1'b1; d_addr = 64'h8000_0020; d_strobe = 8'h00;
    applyStimulus(1'b0, 64'h0);
    checkOutput("rmid_idle_then_data", bus_valid, 1'b1);
    checkOutput("rmid_data_addr", bus_addr, 64'h8000_0020);
    applyStimulus(1'b1, 64'h0000_0000_0000_0042);
    checkOutput("rmid_d_ok", d_ok, 1'b1);
    d_req = 1'b0;
    applyStimulus(1'b0, 64'h0);

    // Repeat the same PTE address twice, then flush and repeat again.
    ptw_req = 1'b1; ptw_addr = 64'h8000_6000;
    applyStimulus(1'b0, 64'h0);
    checkOutput("rep1_bus_valid", bus_valid, 1'b1);
    applyStimulus(1'b1, 64'h0000_0000_6666_0001);
    checkOutput("rep1_dv", ptw_data_valid, 1'b1);
    ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
    ptw_req = 1'b1;
    applyStimulus(1'b0, 64'h0);
`ifdef PTW_PTE_CACHE_EN
    checkOutput("hit_no_bus", bus_valid, 1'b0);
    checkOutput("hit_dv", ptw_data_valid, 1'b1);
    checkOutput("hit_data", ptw_data, 64'h0000_0000_6666_0001);
    ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
`else
    checkOutput("rep2_bus_valid", bus_valid, 1'b1);
    applyStimulus(1'b1, 64'h0000_0000_6666_0002);
    checkOutput("rep2_data", ptw_data, 64'h0000_0000_6666_0002);
    ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);
`endif
    flush = 1'b1;
    applyStimulus(1'b0, 64'h0);
    flush = 1'b0; ptw_req = 1'b1;
    applyStimulus(1'b0, 64'h0);
    checkOutput("flush_bus_valid", bus_valid, 1'b1);
    checkOutput("flush_bus_addr", bus_addr, 64'h8000_6000);
    applyStimulus(1'b1, 64'h0000_0000_6666_0003);
    checkOutput("flush_dv", ptw_data_valid, 1'b1);
    checkOutput("flush_data", ptw_data, 64'h0000_0000_6666_0003);
    ptw_req = 1'b0;
    applyStimulus(1'b0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
